// File: rtl/screen_write_bridge.sv
// Captures Hack CPU stores into the screen window, buffers them in a small FIFO and
// drains one word per cycle to VRAM. Optional power-on clear via `SCREEN_WRITE_CLEAR_EN.
module screen_write_bridge #(
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] SCREEN_BASE  = 16'h4000,
    parameter int          SCREEN_WORDS = 8192
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          writeM,
    input  logic [14:0]                   addressM,
    input  logic [15:0]                   outM,
    input  logic                          vram_ready,
    output logic [12:0]                   vram_addr,
    output logic [15:0]                   vram_data,
    output logic                          vram_wren,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int AW = 13;

    typedef enum logic {RUN, CLEAR} state_t;
`ifdef SCREEN_WRITE_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = RUN;
`endif

    state_t state, state_next;

    logic [AW+15:0] mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [16:0]    addr_ext;
    logic [AW-1:0]  push_addr;
    logic           in_window, push_req, push, pop, full, empty, drain_en, clr_wr;
`ifdef SCREEN_WRITE_CLEAR_EN
    logic [AW-1:0]  clr_ptr;
`endif

    assign addr_ext  = {2'b00, addressM};
    assign in_window = (addr_ext >= {1'b0, SCREEN_BASE}) &&
                       (addr_ext < ({1'b0, SCREEN_BASE} + 17'(SCREEN_WORDS)));
    // Offset fits in 13 bits inside the window, so low-bit subtraction is exact.
    assign push_addr = addressM[AW-1:0] - SCREEN_BASE[AW-1:0];
    assign push_req  = writeM && in_window;
    assign full      = (fifo_level == LW'(FIFO_DEPTH));
    assign empty     = (fifo_level == '0);
    assign pop       = drain_en && !empty && vram_ready;
    assign push      = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) state <= RESET_STATE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
`ifdef SCREEN_WRITE_CLEAR_EN
        if (state == CLEAR && vram_ready && clr_ptr == AW'(SCREEN_WORDS - 1))
            state_next = RUN;
`else
        state_next = RUN;
`endif
    end

    always_comb begin
        drain_en = (state == RUN);
`ifdef SCREEN_WRITE_CLEAR_EN
        busy     = (state == CLEAR);
        clr_wr   = (state == CLEAR) && vram_ready;
`else
        busy     = 1'b0;
        clr_wr   = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {push_addr, outM};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            vram_addr  <= '0;
            vram_data  <= '0;
            vram_wren  <= 1'b0;
`ifdef SCREEN_WRITE_CLEAR_EN
            clr_ptr    <= '0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (push_req && !push) overflow <= 1'b1;
            vram_wren <= pop || clr_wr;
            if (pop) {vram_addr, vram_data} <= mem[rd_ptr];
`ifdef SCREEN_WRITE_CLEAR_EN
            if (clr_wr) begin
                vram_addr <= clr_ptr;
                vram_data <= '0;
                clr_ptr   <= clr_ptr + 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_screen_write_bridge.sv
// Scoreboard bench for screen_write_bridge: stimulus queues expected VRAM writes,
// a negedge monitor pops and compares every vram_wren pulse.
module tb_screen_write_bridge;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        writeM = 1'b0;
    logic [14:0] addressM = '0;
    logic [15:0] outM = '0;
    logic        vram_ready = 1'b1;
    logic [12:0] vram_addr;
    logic [15:0] vram_data;
    logic        vram_wren;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [28:0] exp_q[$];

    screen_write_bridge #(.FIFO_DEPTH(4), .SCREEN_BASE(16'h4000), .SCREEN_WORDS(8192)) dut (
        .clk(clk), .reset(reset), .writeM(writeM), .addressM(addressM), .outM(outM),
        .vram_ready(vram_ready), .vram_addr(vram_addr), .vram_data(vram_data),
        .vram_wren(vram_wren), .fifo_level(fifo_level), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && vram_wren) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wren: got addr=%0d data=%h, required no write", vram_addr, vram_data);
            end else begin
                logic [28:0] e;
                e = exp_q.pop_front();
                if ({vram_addr, vram_data} !== e) begin
                    errors++;
                    $display("FAIL vram_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             vram_addr, vram_data, e[28:16], e[15:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        int t;
        mon_en = 1'b0;
        writeM = 1'b0;
        vram_ready = 1'b1;
        reset = 1'b1;
        step(2);
        chk("rst_vram_addr", vram_addr, 0);
        chk("rst_vram_data", vram_data, 0);
        chk("rst_vram_wren", vram_wren, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
`ifdef SCREEN_WRITE_CLEAR_EN
        chk("rst_busy", busy, 1);
`else
        chk("rst_busy", busy, 0);
`endif
        exp_q.delete();
        reset = 1'b0;
        t = 0;
        while (busy && t < 9000) begin
            step();
            t++;
        end
        chk("clear_done", busy, 0);
        step();
        mon_en = 1'b1;
    endtask

    // Drives one store for one edge; exp_push queues the expected VRAM word.
    task automatic cpu_write(input int addr, input logic [15:0] data, input bit exp_push);
        writeM = 1'b1;
        addressM = 15'(addr);
        outM = data;
        if (exp_push) exp_q.push_back({13'(addr - 16384), data});
        step();
        writeM = 1'b0;
    endtask

    initial begin
        do_reset();

        // Basic capture and two-edge latency.
        cpu_write(16384, 16'hBEEF, 1);
        chk("level_after_push", fifo_level, 1);
        step();
        chk("latency_wren", vram_wren, 1);
        chk("latency_addr", vram_addr, 0);
        chk("latency_data", vram_data, 16'hBEEF);
        step();
        chk("wren_one_cycle", vram_wren, 0);

        // Window boundaries.
        cpu_write(24575, 16'h1234, 1);
        cpu_write(24576, 16'h5678, 0);
        cpu_write(16383, 16'h9ABC, 0);
        step(3);
        chk("boundary_level", fifo_level, 0);

        // RAM write ignored.
        cpu_write(100, 16'hAAAA, 0);
        chk("ram_level", fifo_level, 0);
        step(2);

        // Same-address stores are not merged.
        cpu_write(20000, 16'h0001, 1);
        cpu_write(20000, 16'h0002, 1);
        step(4);

        // Stall, fill, overflow on the fifth store.
        vram_ready = 1'b0;
        cpu_write(16400, 16'h1111, 1);
        cpu_write(16401, 16'h2222, 1);
        cpu_write(16402, 16'h3333, 1);
        cpu_write(16403, 16'h4444, 1);
        chk("full_no_ovf", overflow, 0);
        cpu_write(16404, 16'h5555, 0);
        chk("full_level", fifo_level, 4);
        chk("overflow_set", overflow, 1);
        chk("stall_no_wren", vram_wren, 0);
        vram_ready = 1'b1;
        step(6);
        chk("drain_level", fifo_level, 0);
        chk("overflow_sticky", overflow, 1);

        // Full FIFO accepts a store on the same edge as a pop.
        do_reset();
        vram_ready = 1'b0;
        cpu_write(17000, 16'hA001, 1);
        cpu_write(17001, 16'hA002, 1);
        cpu_write(17002, 16'hA003, 1);
        cpu_write(17003, 16'hA004, 1);
        chk("full2_level", fifo_level, 4);
        vram_ready = 1'b1;
        cpu_write(17004, 16'hA005, 1);
        chk("push_pop_level", fifo_level, 4);
        chk("push_pop_no_ovf", overflow, 0);
        step(7);
        chk("drain2_level", fifo_level, 0);

        // Reset mid-operation discards pending stores.
        vram_ready = 1'b0;
        cpu_write(18000, 16'hDEAD, 0);
        cpu_write(18001, 16'hFACE, 0);
        do_reset();
        step(4);
        chk("post_reset_level", fifo_level, 0);
        chk("post_reset_wren", vram_wren, 0);

        step(2);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
